// File: rtl/alu_multiciclo.sv
// Multi-cycle RV32 integer ALU: one-bit-per-cycle shifter by default, single-cycle
// barrel shifter when ALU_DESPLAZA_RAPIDO_EN is defined.
module alu_multiciclo #(
    parameter int ANCHO = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inicio,
    input  logic [3:0]       op,
    input  logic [ANCHO-1:0] a,
    input  logic [ANCHO-1:0] b,
    output logic [ANCHO-1:0] res,
    output logic             cero,
    output logic             ocupado,
    output logic             listo
);

    // state    | meaning
    // INACTIVO | idle, waiting for inicio
    // DESPLAZA | iterative shift in progress, one bit per cycle
    // LISTO    | res/cero just updated, listo pulse
    typedef enum logic [1:0] {
        INACTIVO = 2'd0,
        DESPLAZA = 2'd1,
        LISTO    = 2'd2
    } estado_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

`ifdef ALU_DESPLAZA_RAPIDO_EN
    localparam bit RAPIDO = 1'b1;
`else
    localparam bit RAPIDO = 1'b0;
`endif

    estado_t          estado_q, estado_d;
    logic [3:0]       op_q, op_d;
    logic [ANCHO-1:0] sh_q, sh_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [ANCHO-1:0] res_q, res_d;
    logic             cero_q, cero_d;
    logic [ANCHO-1:0] paso_sh;

    function automatic logic es_desp(input logic [3:0] cod);
        return (cod == OP_SLL) || (cod == OP_SRL) || (cod == OP_SRA);
    endfunction

    function automatic logic [ANCHO-1:0] opera(input logic [3:0] cod,
                                               input logic [ANCHO-1:0] x,
                                               input logic [ANCHO-1:0] y);
        logic [ANCHO-1:0] r;
        case (cod)
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_SLT:  r = {{(ANCHO-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_SLTU: r = {{(ANCHO-1){1'b0}}, (x < y)};
            OP_XOR:  r = x ^ y;
            OP_OR:   r = x | y;
            OP_AND:  r = x & y;
`ifdef ALU_DESPLAZA_RAPIDO_EN
            OP_SLL:  r = x << y[4:0];
            OP_SRL:  r = x >> y[4:0];
            OP_SRA:  r = $signed(x) >>> y[4:0];
`else
            // iterative build only reaches here for shifts with shamt 0
            OP_SLL, OP_SRL, OP_SRA: r = x;
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [ANCHO-1:0] paso(input logic [3:0] cod,
                                              input logic [ANCHO-1:0] x);
        logic [ANCHO-1:0] r;
        case (cod)
            OP_SLL:  r = {x[ANCHO-2:0], 1'b0};
            OP_SRA:  r = {x[ANCHO-1], x[ANCHO-1:1]};
            default: r = {1'b0, x[ANCHO-1:1]};
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= INACTIVO;
            op_q     <= '0;
            sh_q     <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            cero_q   <= 1'b1;
        end else begin
            estado_q <= estado_d;
            op_q     <= op_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            cero_q   <= cero_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        op_d     = op_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        paso_sh  = paso(op_q, sh_q);
        case (estado_q)
            INACTIVO: begin
                if (inicio) begin
                    op_d = op;
                    if (!RAPIDO && es_desp(op) && (b[4:0] != 5'd0)) begin
                        sh_d     = a;
                        cnt_d    = b[4:0];
                        estado_d = DESPLAZA;
                    end else begin
                        res_d    = opera(op, a, b);
                        estado_d = LISTO;
                    end
                end
            end
            DESPLAZA: begin
                sh_d  = paso_sh;
                cnt_d = cnt_q - 5'd1;
                // terminal count: this edge performs the last shift
                if (cnt_q == 5'd1) begin
                    res_d    = paso_sh;
                    estado_d = LISTO;
                end
            end
            LISTO:    estado_d = INACTIVO;
            default:  estado_d = INACTIVO;
        endcase
        cero_d = (res_d == '0);
    end

    always_comb begin
        ocupado = (estado_q != INACTIVO);
        listo   = (estado_q == LISTO);
        res     = res_q;
        cero    = cero_q;
    end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Self-checking bench for alu_multiciclo: latency/result model checked every cycle
// plus directed literal expectations; honours ALU_DESPLAZA_RAPIDO_EN.
module tb_alu_multiciclo;

`ifdef ALU_DESPLAZA_RAPIDO_EN
    localparam bit RAPIDO = 1'b1;
`else
    localparam bit RAPIDO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inicio;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        cero;
    logic        ocupado;
    logic        listo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_multiciclo #(.ANCHO(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .inicio  (inicio),
        .op      (op),
        .a       (a),
        .b       (b),
        .res     (res),
        .cero    (cero),
        .ocupado (ocupado),
        .listo   (listo)
    );

    task automatic chk(input string nombre, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", nombre, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] modelo(input logic [3:0] o, input logic [31:0] x,
                                           input logic [31:0] y);
        logic signed [31:0] xs;
        int unsigned        s;
        xs = x;
        s  = y[4:0];
        case (o)
            4'b0000: return x + y;
            4'b1000: return x - y;
            4'b0001: return x << s;
            4'b0010: return {31'b0, ($signed(x) < $signed(y))};
            4'b0011: return {31'b0, (x < y)};
            4'b0100: return x ^ y;
            4'b0101: return x >> s;
            4'b1101: return xs >>> s;
            4'b0110: return x | y;
            4'b0111: return x & y;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int latencia(input logic [3:0] o, input logic [31:0] y);
        int s;
        s = int'(y[4:0]);
        if (!RAPIDO && (o == 4'b0001 || o == 4'b0101 || o == 4'b1101) && s != 0)
            return s + 1;
        return 1;
    endfunction

    // Model: m_cnt = busy cycles remaining; listo is the last of them.
    int          m_cnt  = 0;
    logic [31:0] m_pend = 32'h0;
    logic [31:0] m_res  = 32'h0;
    logic        m_cero = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  = 0;
            m_res  = 32'h0;
            m_cero = 1'b1;
        end else if (m_cnt == 0) begin
            if (inicio === 1'b1) begin
                m_pend = modelo(op, a, b);
                m_cnt  = latencia(op, b);
            end
        end else begin
            m_cnt--;
        end
        if (m_cnt == 1) begin
            m_res  = m_pend;
            m_cero = (m_pend == 32'h0);
        end
    end

    int n_listo = 0;

    always @(negedge clk) begin
        if (listo === 1'b1) n_listo++;
        chk("ocupado", {31'b0, ocupado}, {31'b0, (m_cnt > 0)});
        chk("listo",   {31'b0, listo},   {31'b0, (m_cnt == 1)});
        chk("res",     res,              m_res);
        chk("cero",    {31'b0, cero},    {31'b0, m_cero});
    end

    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output int ed);
        @(posedge clk); #1;
        inicio = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        inicio = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
        ed = 1;
        while (listo !== 1'b1 && ed < 64) begin
            @(posedge clk); #1;
            ed++;
        end
        if (listo !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL timeout: listo not seen after %0d edges, required within 33", ed);
        end
        r = res;
    endtask

    logic [31:0] r;
    int          ed;
    int          base;

    initial begin
        rst_n = 1'b0; inicio = 1'b0; op = 4'h0; a = 32'h0; b = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_res",     res,              32'h0);
        chk("reset_cero",    {31'b0, cero},    32'h1);
        chk("reset_ocupado", {31'b0, ocupado}, 32'h0);
        rst_n = 1'b1;

        run_op(4'b0000, 32'd5, 32'd7, r, ed);
        chk("add_res", r, 32'd12);
        chk("add_cero", {31'b0, cero}, 32'h0);
        chk("add_lat", 32'(ed), 32'd1);

        run_op(4'b1000, 32'h1234, 32'h1234, r, ed);
        chk("sub_res", r, 32'h0);
        chk("sub_cero", {31'b0, cero}, 32'h1);

        run_op(4'b1101, 32'h8000_0000, 32'd4, r, ed);
        chk("sra4_res", r, 32'hF800_0000);
        chk("sra4_lat", 32'(ed), RAPIDO ? 32'd1 : 32'd5);

        run_op(4'b0010, 32'hFFFF_FFFF, 32'd1, r, ed);
        chk("slt_res", r, 32'd1);
        run_op(4'b0011, 32'hFFFF_FFFF, 32'd1, r, ed);
        chk("sltu_res", r, 32'd0);
        chk("sltu_cero", {31'b0, cero}, 32'h1);

        run_op(4'b0001, 32'h3, 32'd5, r, ed);
        chk("sll5_res", r, 32'h60);
        chk("sll5_lat", 32'(ed), RAPIDO ? 32'd1 : 32'd6);
        run_op(4'b0101, 32'hF000_0000, 32'h24, r, ed);
        chk("srl_hi_bits_res", r, 32'h0F00_0000);
        run_op(4'b0001, 32'hABCD, 32'h20, r, ed);
        chk("sll0_res", r, 32'hABCD);
        chk("sll0_lat", 32'(ed), 32'd1);
        run_op(4'b1101, 32'h8000_0000, 32'd31, r, ed);
        chk("sra31_res", r, 32'hFFFF_FFFF);
        chk("sra31_lat", 32'(ed), RAPIDO ? 32'd1 : 32'd32);
        run_op(4'b0101, 32'h8000_0000, 32'd31, r, ed);
        chk("srl31_res", r, 32'h1);

        run_op(4'b0100, 32'hF0F0_00FF, 32'h0FF0_0F0F, r, ed);
        chk("xor_res", r, 32'hFF00_0FF0);
        run_op(4'b0110, 32'hF0F0_00FF, 32'h0FF0_0F0F, r, ed);
        chk("or_res", r, 32'hFFF0_0FFF);
        run_op(4'b0111, 32'hF0F0_00FF, 32'h0FF0_0F0F, r, ed);
        chk("and_res", r, 32'h00F0_000F);
        run_op(4'b1001, 32'h1, 32'h1, r, ed);
        chk("undef_res", r, 32'h0);
        chk("undef_lat", 32'(ed), 32'd1);

        // second request while a 10-bit shift is running must vanish
        @(posedge clk); #1;
        base = n_listo;
        inicio = 1'b1; op = 4'b0001; a = 32'h1; b = 32'd10;
        @(posedge clk); #1;
        inicio = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (!RAPIDO) begin
            inicio = 1'b1; op = 4'b0000; a = 32'd100; b = 32'd200;
        end
        @(posedge clk); #1;
        inicio = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("busy_listo_count", 32'(n_listo - base), 32'd1);
        chk("busy_res", res, 32'h400);

        // reset while shifting
        inicio = 1'b1; op = 4'b0101; a = 32'hFFFF_FFFF; b = 32'd8;
        @(posedge clk); #1;
        inicio = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        base = n_listo;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mid_res",     res,              32'h0);
        chk("rst_mid_cero",    {31'b0, cero},    32'h1);
        chk("rst_mid_ocupado", {31'b0, ocupado}, 32'h0);
        chk("rst_mid_listo",   {31'b0, listo},   32'h0);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("rst_no_listo", 32'(n_listo - base), 32'd0);
        run_op(4'b0000, 32'd1, 32'd1, r, ed);
        chk("post_rst_add", r, 32'd2);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
